// File: rtl/multi_timer_ctrl.sv
// multi_timer_ctrl: NUM_CH countdown timers sharing one 1 Hz tick, with BCD display, hourglass level, LED and buzzer
// for the selected channel. Define TIMER_AUTORELOAD_EN to make expired channels reload their start time and rerun.
module multi_timer_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int RING_SEC    = 3,
    parameter int MAX_HOUR    = 23,
    parameter int SAND_LEVELS = 9
) (
    input  logic                      clk_1k,
    input  logic                      rst_n,
    input  logic                      tick_1hz,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel,
    input  logic                      btn_h_inc,
    input  logic                      btn_m_inc,
    input  logic                      btn_s_inc,
    input  logic                      btn_add,
    input  logic [5:0]                add_min,
    input  logic                      btn_start,
    input  logic                      btn_pause,
    input  logic                      btn_clear,
    output logic [3:0]                tm_h_tens,
    output logic [3:0]                tm_h_ones,
    output logic [3:0]                tm_m_tens,
    output logic [3:0]                tm_m_ones,
    output logic [3:0]                tm_s_tens,
    output logic [3:0]                tm_s_ones,
    output logic [1:0]                sel_state,
    output logic [NUM_CH-1:0]         ch_running,
    output logic [NUM_CH-1:0]         ch_ringing,
    output logic [3:0]                sand_count,
    output logic                      led_blink,
    output logic                      piezo_out
);

    localparam int         SW        = $clog2(NUM_CH);
    localparam logic [4:0] MAX_H     = 5'(MAX_HOUR);
    localparam logic [7:0] RING_INIT = 8'(RING_SEC);
    localparam logic [3:0] SAND_FULL = 4'(SAND_LEVELS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_RINGING = 2'd3
    } state_t;

    logic [NUM_CH-1:0][4:0]  hour_all;
    logic [NUM_CH-1:0][5:0]  min_all;
    logic [NUM_CH-1:0][5:0]  sec_all;
    logic [NUM_CH-1:0][16:0] total_all;
    logic [NUM_CH-1:0][16:0] start_all;
    logic [NUM_CH-1:0][1:0]  state_all;
    logic [NUM_CH-1:0][1:0]  state_next_all;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [SW-1:0] CH_ID = SW'(gi);

        state_t      state_reg, state_next;
        logic [4:0]  hour_reg, hour_next;
        logic [5:0]  min_reg, min_next;
        logic [5:0]  sec_reg, sec_next;
        logic [16:0] start_reg, start_next;
        logic [7:0]  ring_reg, ring_next;
        logic        sel;
        logic        acted;
        logic [16:0] total;
        logic [6:0]  min_sum;

        assign sel     = (ch_sel == CH_ID);
        assign total   = 17'(hour_reg) * 17'd3600 + 17'(min_reg) * 17'd60 + 17'(sec_reg);
        assign min_sum = 7'(min_reg) + 7'(add_min);

        always_ff @(posedge clk_1k or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= ST_IDLE;
                hour_reg  <= '0;
                min_reg   <= '0;
                sec_reg   <= '0;
                start_reg <= '0;
                ring_reg  <= '0;
            end else begin
                state_reg <= state_next;
                hour_reg  <= hour_next;
                min_reg   <= min_next;
                sec_reg   <= sec_next;
                start_reg <= start_next;
                ring_reg  <= ring_next;
            end
        end

        // A button that changes this channel's state consumes a coincident tick.
        always_comb begin
            state_next = state_reg;
            hour_next  = hour_reg;
            min_next   = min_reg;
            sec_next   = sec_reg;
            start_next = start_reg;
            ring_next  = ring_reg;
            acted      = 1'b0;

            if (sel && btn_clear) begin
                state_next = ST_IDLE;
                hour_next  = '0;
                min_next   = '0;
                sec_next   = '0;
                start_next = '0;
                ring_next  = '0;
                acted      = 1'b1;
            end else if (sel && btn_pause) begin
                if (state_reg == ST_RUNNING) begin
                    state_next = ST_PAUSED;
                    acted      = 1'b1;
                end
            end else if (sel && btn_start) begin
                if (state_reg == ST_IDLE && total != 17'd0) begin
                    state_next = ST_RUNNING;
                    start_next = total;
                    acted      = 1'b1;
                end else if (state_reg == ST_PAUSED) begin
                    state_next = ST_RUNNING;
                    acted      = 1'b1;
                end
            end else if (sel && state_reg == ST_IDLE) begin
                if (btn_h_inc) begin
                    hour_next = (hour_reg == MAX_H) ? 5'd0 : hour_reg + 5'd1;
                end
                if (btn_add) begin
                    if (min_sum >= 7'd60) begin
                        min_next = 6'(min_sum - 7'd60);
                        if (hour_next != MAX_H) begin
                            hour_next = hour_next + 5'd1;
                        end
                    end else begin
                        min_next = min_sum[5:0];
                    end
                end else if (btn_m_inc) begin
                    min_next = (min_reg == 6'd59) ? 6'd0 : min_reg + 6'd1;
                end
                if (btn_s_inc) begin
                    sec_next = (sec_reg == 6'd59) ? 6'd0 : sec_reg + 6'd1;
                end
            end

            if (tick_1hz && !acted) begin
                case (state_reg)
                    ST_RUNNING: begin
                        if (total == 17'd0) begin
                            state_next = ST_RINGING;
                            ring_next  = RING_INIT;
                        end else if (sec_reg != 6'd0) begin
                            sec_next = sec_reg - 6'd1;
                        end else if (min_reg != 6'd0) begin
                            min_next = min_reg - 6'd1;
                            sec_next = 6'd59;
                        end else begin
                            hour_next = hour_reg - 5'd1;
                            min_next  = 6'd59;
                            sec_next  = 6'd59;
                        end
                    end
                    ST_RINGING: begin
                        if (ring_reg == 8'd0) begin
`ifdef TIMER_AUTORELOAD_EN
                            state_next = ST_RUNNING;
                            hour_next  = 5'(start_reg / 17'd3600);
                            min_next   = 6'((start_reg % 17'd3600) / 17'd60);
                            sec_next   = 6'(start_reg % 17'd60);
`else
                            state_next = ST_IDLE;
                            hour_next  = '0;
                            min_next   = '0;
                            sec_next   = '0;
                            start_next = '0;
`endif
                        end else begin
                            ring_next = ring_reg - 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign hour_all[gi]       = hour_reg;
        assign min_all[gi]        = min_reg;
        assign sec_all[gi]        = sec_reg;
        assign total_all[gi]      = total;
        assign start_all[gi]      = start_reg;
        assign state_all[gi]      = state_reg;
        assign state_next_all[gi] = state_next;
        assign ch_running[gi]     = (state_reg == ST_RUNNING);
        assign ch_ringing[gi]     = (state_reg == ST_RINGING);
    end

    logic [4:0]  sel_hour;
    logic [5:0]  sel_min;
    logic [5:0]  sel_sec;
    logic [16:0] sel_total;
    logic [16:0] sel_start;

    assign sel_hour  = hour_all[ch_sel];
    assign sel_min   = min_all[ch_sel];
    assign sel_sec   = sec_all[ch_sel];
    assign sel_total = total_all[ch_sel];
    assign sel_start = start_all[ch_sel];
    assign sel_state = state_all[ch_sel];

    assign tm_h_tens = 4'(sel_hour / 5'd10);
    assign tm_h_ones = 4'(sel_hour % 5'd10);
    assign tm_m_tens = 4'(sel_min / 6'd10);
    assign tm_m_ones = 4'(sel_min % 6'd10);
    assign tm_s_tens = 4'(sel_sec / 6'd10);
    assign tm_s_ones = 4'(sel_sec % 6'd10);

    // Rounded ratio computed as (2*remain*levels + start) / (2*start).
    logic [23:0] sand_num;
    logic [23:0] sand_den;
    logic [23:0] sand_q;

    assign sand_num = 24'(sel_total) * 24'(2 * SAND_LEVELS) + 24'(sel_start);
    assign sand_den = {6'd0, sel_start, 1'b0};

    always_comb begin
        sand_q     = '0;
        sand_count = SAND_FULL;
        if (sand_den != 24'd0) begin
            sand_q = sand_num / sand_den;
        end
        case (sel_state)
            ST_IDLE:    sand_count = SAND_FULL;
            ST_RINGING: sand_count = 4'd0;
            default: begin
                if (sand_den == 24'd0 || sand_q >= 24'(SAND_LEVELS)) begin
                    sand_count = SAND_FULL;
                end else if (sand_q == 24'd0 && sel_total != 17'd0) begin
                    sand_count = 4'd1;
                end else begin
                    sand_count = 4'(sand_q);
                end
            end
        endcase
    end

    logic [9:0] blink_reg;
    logic       enter_run;
    logic       piezo_reg;

    assign enter_run = (state_next_all[ch_sel] == ST_RUNNING) && (state_all[ch_sel] != ST_RUNNING);

    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            blink_reg <= '0;
            piezo_reg <= 1'b0;
        end else begin
            if (enter_run || blink_reg == 10'd999) begin
                blink_reg <= '0;
            end else begin
                blink_reg <= blink_reg + 10'd1;
            end
            piezo_reg <= (|ch_ringing) ? ~piezo_reg : 1'b0;
        end
    end

    assign led_blink = (sel_state == ST_RUNNING) ? (blink_reg < 10'd500) : (sel_state == ST_PAUSED);
    assign piezo_out = piezo_reg;

endmodule

// File: tb/tb_multi_timer_ctrl.sv
// Testbench for multi_timer_ctrl: directed table, corner-case sequences and random stimulus against a
// seconds-based reference model.
module tb_multi_timer_ctrl;
    localparam int NUM_CH      = 4;
    localparam int RING_SEC    = 3;
    localparam int MAX_HOUR    = 23;
    localparam int SAND_LEVELS = 9;

    logic        clk_1k;
    logic        rst_n;
    logic        tick_1hz;
    logic [1:0]  ch_sel;
    logic        btn_h_inc, btn_m_inc, btn_s_inc, btn_add;
    logic [5:0]  add_min;
    logic        btn_start, btn_pause, btn_clear;
    logic [3:0]  tm_h_tens, tm_h_ones, tm_m_tens, tm_m_ones, tm_s_tens, tm_s_ones;
    logic [1:0]  sel_state;
    logic [NUM_CH-1:0] ch_running, ch_ringing;
    logic [3:0]  sand_count;
    logic        led_blink, piezo_out;

    multi_timer_ctrl #(
        .NUM_CH(NUM_CH), .RING_SEC(RING_SEC), .MAX_HOUR(MAX_HOUR), .SAND_LEVELS(SAND_LEVELS)
    ) dut (
        .clk_1k(clk_1k), .rst_n(rst_n), .tick_1hz(tick_1hz), .ch_sel(ch_sel),
        .btn_h_inc(btn_h_inc), .btn_m_inc(btn_m_inc), .btn_s_inc(btn_s_inc), .btn_add(btn_add),
        .add_min(add_min), .btn_start(btn_start), .btn_pause(btn_pause), .btn_clear(btn_clear),
        .tm_h_tens(tm_h_tens), .tm_h_ones(tm_h_ones), .tm_m_tens(tm_m_tens), .tm_m_ones(tm_m_ones),
        .tm_s_tens(tm_s_tens), .tm_s_ones(tm_s_ones), .sel_state(sel_state), .ch_running(ch_running),
        .ch_ringing(ch_ringing), .sand_count(sand_count), .led_blink(led_blink), .piezo_out(piezo_out)
    );

    initial clk_1k = 1'b0;
    always #5 clk_1k = ~clk_1k;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining time kept as plain seconds.
    int m_rem   [NUM_CH];
    int m_st    [NUM_CH];
    int m_ring  [NUM_CH];
    int m_state [NUM_CH];
    int m_blink;
    bit m_piezo;

    typedef struct {
        int ch; bit hi; bit mi; bit si; bit add; int amin; bit start; bit pause; bit clear; bit tick;
        int eh; int em; int es; int estate; int esand;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] bcd_of(input int rem);
        int h, m, s;
        h = rem / 3600;
        m = (rem / 60) % 60;
        s = rem % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int model_sand(input int c);
        real x;
        int  q;
        if (m_state[c] == 0 || m_st[c] == 0) return SAND_LEVELS;
        if (m_state[c] == 3) return 0;
        x = real'(m_rem[c]) * SAND_LEVELS / real'(m_st[c]);
        q = int'($floor(x + 0.5));
        if (q > SAND_LEVELS) q = SAND_LEVELS;
        if (q == 0 && m_rem[c] > 0) q = 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_rem[c] = 0; m_st[c] = 0; m_ring[c] = 0; m_state[c] = 0;
        end
        m_blink = 0;
        m_piezo = 1'b0;
    endtask

    task automatic model_step();
        int  sel, old_sel_state, h, mm, s, sum;
        bit  any_ring, acted;
        sel = int'(ch_sel);
        old_sel_state = m_state[sel];
        any_ring = 1'b0;
        for (int c = 0; c < NUM_CH; c++) if (m_state[c] == 3) any_ring = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            acted = 1'b0;
            if (c == sel) begin
                if (btn_clear) begin
                    m_state[c] = 0; m_rem[c] = 0; m_st[c] = 0; m_ring[c] = 0; acted = 1'b1;
                end else if (btn_pause) begin
                    if (m_state[c] == 1) begin m_state[c] = 2; acted = 1'b1; end
                end else if (btn_start) begin
                    if (m_state[c] == 0 && m_rem[c] > 0) begin
                        m_state[c] = 1; m_st[c] = m_rem[c]; acted = 1'b1;
                    end else if (m_state[c] == 2) begin
                        m_state[c] = 1; acted = 1'b1;
                    end
                end else if (m_state[c] == 0) begin
                    h = m_rem[c] / 3600; mm = (m_rem[c] / 60) % 60; s = m_rem[c] % 60;
                    if (btn_h_inc) h = (h == MAX_HOUR) ? 0 : h + 1;
                    if (btn_add) begin
                        sum = mm + int'(add_min);
                        mm = sum % 60;
                        if (sum >= 60 && h < MAX_HOUR) h++;
                    end else if (btn_m_inc) mm = (mm + 1) % 60;
                    if (btn_s_inc) s = (s + 1) % 60;
                    m_rem[c] = h * 3600 + mm * 60 + s;
                end
            end
            if (tick_1hz && !acted) begin
                if (m_state[c] == 1) begin
                    if (m_rem[c] == 0) begin m_state[c] = 3; m_ring[c] = RING_SEC; end
                    else m_rem[c]--;
                end else if (m_state[c] == 3) begin
                    if (m_ring[c] == 0) begin
`ifdef TIMER_AUTORELOAD_EN
                        m_state[c] = 1; m_rem[c] = m_st[c];
`else
                        m_state[c] = 0; m_rem[c] = 0; m_st[c] = 0;
`endif
                    end else m_ring[c]--;
                end
            end
        end
        m_blink = (m_state[sel] == 1 && old_sel_state != 1) ? 0 : (m_blink + 1) % 1000;
        m_piezo = any_ring ? !m_piezo : 1'b0;
    endtask

    task automatic check_outputs();
        int c;
        logic [NUM_CH-1:0] er, eg;
        c = int'(ch_sel);
        for (int i = 0; i < NUM_CH; i++) begin
            er[i] = (m_state[i] == 1);
            eg[i] = (m_state[i] == 3);
        end
        check("bcd", {8'd0, tm_h_tens, tm_h_ones, tm_m_tens, tm_m_ones, tm_s_tens, tm_s_ones},
              {8'd0, bcd_of(m_rem[c])});
        check("sel_state", 32'(sel_state), 32'(m_state[c]));
        check("sand", 32'(sand_count), 32'(model_sand(c)));
        check("ch_running", 32'(ch_running), 32'(er));
        check("ch_ringing", 32'(ch_ringing), 32'(eg));
        check("led", 32'(led_blink), (m_state[c] == 1) ? 32'(m_blink < 500) : 32'(m_state[c] == 2));
        check("piezo", 32'(piezo_out), 32'(m_piezo));
    endtask

    task automatic idle_inputs();
        tick_1hz = 0; btn_h_inc = 0; btn_m_inc = 0; btn_s_inc = 0; btn_add = 0;
        btn_start = 0; btn_pause = 0; btn_clear = 0;
    endtask

    task automatic step();
        @(posedge clk_1k);
        model_step();
        #1;
        check_outputs();
        idle_inputs();
    endtask

    task automatic tick_n(input int n, input int ch);
        for (int i = 0; i < n; i++) begin
            ch_sel = 2'(ch); tick_1hz = 1; step();
            step();
        end
    endtask

    function automatic int dut_secs();
        return (int'(tm_h_tens) * 10 + int'(tm_h_ones)) * 3600 +
               (int'(tm_m_tens) * 10 + int'(tm_m_ones)) * 60 + int'(tm_s_tens) * 10 + int'(tm_s_ones);
    endfunction

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 1, 55, 0, 0, 0, 0,  0, 55, 0, 0, 9};
        tbl[1]  = '{1, 0, 0, 0, 1, 10, 0, 0, 0, 0,  1,  5, 0, 0, 9};
        tbl[2]  = '{1, 1, 1, 1, 0,  0, 0, 0, 0, 0,  2,  6, 1, 0, 9};
        tbl[3]  = '{1, 0, 1, 0, 1,  5, 0, 0, 0, 0,  2, 11, 1, 0, 9};
        tbl[4]  = '{1, 0, 0, 0, 0,  0, 0, 0, 1, 0,  0,  0, 0, 0, 9};
        tbl[5]  = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0,  0, 0, 0, 9};
        tbl[6]  = '{1, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0,  0, 1, 0, 9};
        tbl[7]  = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0,  0, 1, 1, 9};
        tbl[8]  = '{1, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0,  0, 1, 1, 9};
        tbl[9]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0,  0, 0, 1, 0};
        tbl[10] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0,  0, 0, 3, 0};
        tbl[11] = '{1, 0, 0, 0, 0,  0, 1, 0, 1, 0,  0,  0, 0, 0, 9};
        tbl[12] = '{1, 0, 0, 0, 0,  0, 0, 1, 0, 1,  0,  0, 0, 0, 9};

        rst_n = 0; ch_sel = 0; add_min = 0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk_1k);
        #1;
        check("rst_bcd", {8'd0, tm_h_tens, tm_h_ones, tm_m_tens, tm_m_ones, tm_s_tens, tm_s_ones}, 32'd0);
        check("rst_state", 32'(sel_state), 32'd0);
        check("rst_sand", 32'(sand_count), 32'(SAND_LEVELS));
        check("rst_led", 32'(led_blink), 32'd0);
        check("rst_piezo", 32'(piezo_out), 32'd0);
        rst_n = 1;
        step();

        for (int i = 0; i < 13; i++) begin
            ch_sel = 2'(tbl[i].ch); btn_h_inc = tbl[i].hi; btn_m_inc = tbl[i].mi; btn_s_inc = tbl[i].si;
            btn_add = tbl[i].add; add_min = 6'(tbl[i].amin); btn_start = tbl[i].start;
            btn_pause = tbl[i].pause; btn_clear = tbl[i].clear; tick_1hz = tbl[i].tick;
            step();
            check($sformatf("tbl%0d_time", i), 32'(dut_secs()), 32'(tbl[i].eh * 3600 + tbl[i].em * 60 + tbl[i].es));
            check($sformatf("tbl%0d_state", i), 32'(sel_state), 32'(tbl[i].estate));
            check($sformatf("tbl%0d_sand", i), 32'(sand_count), 32'(tbl[i].esand));
        end

        // Hour wrap, then 23:55 + 10 min saturates the hour.
        ch_sel = 1;
        for (int i = 0; i < MAX_HOUR + 1; i++) begin btn_h_inc = 1; step(); end
        check("hour_wrap", 32'(dut_secs()), 32'd0);
        for (int i = 0; i < MAX_HOUR; i++) begin btn_h_inc = 1; step(); end
        btn_add = 1; add_min = 55; step();
        btn_add = 1; add_min = 10; step();
        check("add_saturate", 32'(dut_secs()), 32'(23 * 3600 + 5 * 60));
        btn_clear = 1; step();

        // Short countdown through ringing back to idle.
        ch_sel = 0;
        btn_s_inc = 1; step();
        btn_s_inc = 1; step();
        btn_start = 1; step();
        check("c0_running", 32'(sel_state), 32'd1);
        tick_n(3, 0);
        check("c0_ringing_state", 32'(sel_state), 32'd3);
        check("c0_ringing_flag", 32'(ch_ringing[0]), 32'd1);
        tick_n(4, 0);
        check("c0_back_idle", 32'(sel_state), 32'd0);
        check("c0_zero", 32'(dut_secs()), 32'd0);

        // Pause/resume with blink exercised over more than one LED period.
        ch_sel = 2;
        btn_add = 1; add_min = 1; step();
        btn_start = 1; step();
        repeat (1200) step();
        tick_n(10, 2);
        btn_pause = 1; step();
        tick_n(5, 2);
        check("pause_hold", 32'(dut_secs()), 32'd50);
        check("pause_led", 32'(led_blink), 32'd1);
        btn_start = 1; step();
        tick_n(1, 2);
        check("resume_tick", 32'(dut_secs()), 32'd49);
        btn_clear = 1; step();

        // Two channels counting concurrently.
        ch_sel = 0;
        for (int i = 0; i < 10; i++) begin btn_s_inc = 1; step(); end
        btn_start = 1; step();
        ch_sel = 3;
        btn_h_inc = 1; step();
        btn_start = 1; step();
        tick_n(11, 3);
        check("conc_ch0_ringing", 32'(ch_ringing[0]), 32'd1);
        check("conc_ch3_time", 32'(dut_secs()), 32'(59 * 60 + 49));
        check("conc_ch3_sand", 32'(sand_count), 32'd9);

        // Asynchronous reset while ringing.
        step(); step();
        #2 rst_n = 0;
        #1;
        check("arst_piezo", 32'(piezo_out), 32'd0);
        check("arst_ringing", 32'(ch_ringing), 32'd0);
        check("arst_running", 32'(ch_running), 32'd0);
        check("arst_state", 32'(sel_state), 32'd0);
        check("arst_sand", 32'(sand_count), 32'(SAND_LEVELS));
        model_reset();
        repeat (2) @(posedge clk_1k);
        #1 rst_n = 1;
        step();

        ch_sel = 2;
        btn_s_inc = 1; step();
        btn_clear = 1; btn_start = 1; step();
        check("clear_over_start", 32'(sel_state), 32'd0);

        // Expiry of a 1 s timer: reloads and reruns when auto-reload is built in, otherwise idles.
        ch_sel = 1;
        btn_s_inc = 1; step();
        btn_start = 1; step();
        tick_n(2 + RING_SEC + 1, 1);
`ifdef TIMER_AUTORELOAD_EN
        check("expiry_state", 32'(sel_state), 32'd1);
        check("expiry_time", 32'(dut_secs()), 32'd1);
`else
        check("expiry_state", 32'(sel_state), 32'd0);
        check("expiry_time", 32'(dut_secs()), 32'd0);
`endif

        for (int i = 0; i < 4000; i++) begin
            ch_sel    = 2'($urandom_range(0, NUM_CH - 1));
            btn_h_inc = ($urandom_range(0, 99) < 10);
            btn_m_inc = ($urandom_range(0, 99) < 10);
            btn_s_inc = ($urandom_range(0, 99) < 12);
            btn_add   = ($urandom_range(0, 99) < 6);
            add_min   = 6'($urandom_range(0, 59));
            btn_start = ($urandom_range(0, 99) < 12);
            btn_pause = ($urandom_range(0, 99) < 4);
            btn_clear = ($urandom_range(0, 99) < 2);
            tick_1hz  = ($urandom_range(0, 99) < 15);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
